// File: rtl/chroma_timing_ctrl_if.sv
// Control/status bundle between the chroma timing sequencer and its host.
// The host drives the tick and mode requests; the sequencer drives sync, blank and counters.
interface chroma_timing_ctrl_if;
  logic       cs_tick;
  logic       cs_pnsel_req;
  logic       cs_colour_req;
  logic       cs_hsync;
  logic       cs_vsync;
  logic       cs_csync;
  logic       cs_blank;
  logic       cs_cg_enable;
  logic       cs_pnsel;
  logic [8:0] cs_hcnt;
  logic [8:0] cs_vcnt;
  logic       cs_frame_start;

  modport master (
    output cs_tick, cs_pnsel_req, cs_colour_req,
    input  cs_hsync, cs_vsync, cs_csync, cs_blank, cs_cg_enable,
           cs_pnsel, cs_hcnt, cs_vcnt, cs_frame_start
  );

  modport slave (
    input  cs_tick, cs_pnsel_req, cs_colour_req,
    output cs_hsync, cs_vsync, cs_csync, cs_blank, cs_cg_enable,
           cs_pnsel, cs_hcnt, cs_vcnt, cs_frame_start
  );
endinterface

// File: rtl/chroma_timing_ctrl.sv
// Line/frame sequencer for the composite chroma path: pixel/line counters, vertical-region FSM
// and registered sync/blank decodes. Macro CHROMA_SERRATION_EN adds vsync serration gaps to csync.
module chroma_timing_ctrl #(
  parameter int H_TOTAL        = 448,
  parameter int H_SYNC_LEN     = 33,
  parameter int H_ACTIVE_START = 80,
  parameter int H_ACTIVE_LEN   = 352,
  parameter int V_TOTAL_PAL    = 312,
  parameter int V_TOTAL_NTSC   = 262,
  parameter int V_SYNC_LEN     = 4,
  parameter int V_ACTIVE_START = 16,
  parameter int V_ACTIVE_LEN   = 240
) (
  input  logic                 cs_clock,
  input  logic                 cs_reset_n,
  chroma_timing_ctrl_if.slave  bus
);

  localparam logic [8:0] L_HMAX      = 9'(H_TOTAL - 1);
  localparam logic [8:0] L_HSYNC     = 9'(H_SYNC_LEN);
  localparam logic [8:0] L_HACT_S    = 9'(H_ACTIVE_START);
  localparam logic [8:0] L_HACT_E    = 9'(H_ACTIVE_START + H_ACTIVE_LEN);
  localparam logic [8:0] L_VMAX_PAL  = 9'(V_TOTAL_PAL - 1);
  localparam logic [8:0] L_VMAX_NTSC = 9'(V_TOTAL_NTSC - 1);
  localparam logic [8:0] L_VSYNC     = 9'(V_SYNC_LEN);
  localparam logic [8:0] L_VACT_S    = 9'(V_ACTIVE_START);
  localparam logic [8:0] L_VACT_E    = 9'(V_ACTIVE_START + V_ACTIVE_LEN);

  if (H_TOTAL >= 512 || V_TOTAL_PAL >= 512 || V_TOTAL_NTSC >= 512 ||
      H_ACTIVE_START + H_ACTIVE_LEN >= 512 ||
      V_ACTIVE_START + V_ACTIVE_LEN > V_TOTAL_NTSC) begin : g_param_err
    $error("chroma_timing_ctrl: illegal timing parameter set");
  end

  typedef enum logic [1:0] {
    ST_VSYNC     = 2'd0,
    ST_TOP_BLANK = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_BOT_BLANK = 2'd3
  } state_t;

  state_t     r_state;
  logic [8:0] r_hcnt;
  logic [8:0] r_vcnt;
  logic       r_pnsel;
  logic       r_colour;
  logic       r_fwrap;
  logic       r_frame_start;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_csync;
  logic       r_blank;
  logic       r_cg_enable;

  logic [8:0] w_vmax;
  logic       w_hwrap;
  logic       w_vwrap;
  logic [8:0] w_vcnt_nxt;
  logic       w_hs_act;
  logic       w_vs_act;
  logic       w_h_act;
  logic       w_disp;
  logic       w_csync;

  // Frame length follows the applied system, so a pending request never shortens a running frame.
  assign w_vmax     = r_pnsel ? L_VMAX_NTSC : L_VMAX_PAL;
  assign w_hwrap    = (r_hcnt == L_HMAX);
  assign w_vwrap    = w_hwrap && (r_vcnt == w_vmax);
  assign w_vcnt_nxt = w_vwrap ? 9'd0 : (r_vcnt + 9'd1);

  assign w_hs_act = (r_hcnt < L_HSYNC);
  assign w_vs_act = (r_state == ST_VSYNC);
  assign w_h_act  = (r_hcnt >= L_HACT_S) && (r_hcnt < L_HACT_E);
  assign w_disp   = (r_state == ST_ACTIVE) && w_h_act;

`ifdef CHROMA_SERRATION_EN
  localparam logic [8:0] L_SER1_S = 9'(H_TOTAL / 2 - H_SYNC_LEN);
  localparam logic [8:0] L_SER1_E = 9'(H_TOTAL / 2);
  localparam logic [8:0] L_SER2_S = 9'(H_TOTAL - H_SYNC_LEN);

  logic w_ser_gap;
  // Gaps end on each half-line so the equaliser edges keep the receiver's line oscillator locked.
  assign w_ser_gap = ((r_hcnt >= L_SER1_S) && (r_hcnt < L_SER1_E)) || (r_hcnt >= L_SER2_S);
  assign w_csync   = w_vs_act ? w_ser_gap : !w_hs_act;
`else
  assign w_csync   = !(w_hs_act ^ w_vs_act);
`endif

  always_ff @(posedge cs_clock or negedge cs_reset_n) begin
    if (!cs_reset_n) begin
      r_state       <= ST_VSYNC;
      r_hcnt        <= 9'd0;
      r_vcnt        <= 9'd0;
      r_pnsel       <= 1'b0;
      r_colour      <= 1'b0;
      r_fwrap       <= 1'b0;
      r_frame_start <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_csync       <= 1'b1;
      r_blank       <= 1'b1;
      r_cg_enable   <= 1'b0;
    end else begin
      r_fwrap <= 1'b0;
      if (bus.cs_tick) begin
        if (w_hwrap) begin
          r_hcnt <= 9'd0;
          r_vcnt <= w_vcnt_nxt;
          // Regions are only ever entered in order; the frame wrap is the single way back to VSYNC.
          case (r_state)
            ST_VSYNC: begin
              if (w_vcnt_nxt >= L_VSYNC) r_state <= ST_TOP_BLANK;
            end
            ST_TOP_BLANK: begin
              if (w_vcnt_nxt >= L_VACT_S) r_state <= ST_ACTIVE;
            end
            ST_ACTIVE: begin
              if (w_vcnt_nxt == 9'd0)          r_state <= ST_VSYNC;
              else if (w_vcnt_nxt >= L_VACT_E) r_state <= ST_BOT_BLANK;
            end
            ST_BOT_BLANK: begin
              if (w_vcnt_nxt == 9'd0) r_state <= ST_VSYNC;
            end
            default: r_state <= ST_VSYNC;
          endcase
        end else begin
          r_hcnt <= r_hcnt + 9'd1;
        end
        if (w_vwrap) begin
          r_pnsel  <= bus.cs_pnsel_req;
          r_colour <= bus.cs_colour_req;
          r_fwrap  <= 1'b1;
        end
      end
      // Decodes lag the counters by one clock; frame_start is delayed to stay aligned with them.
      r_frame_start <= r_fwrap;
      r_hsync       <= !w_hs_act;
      r_vsync       <= !w_vs_act;
      r_csync       <= w_csync;
      r_blank       <= !w_disp;
      r_cg_enable   <= r_colour && w_disp;
    end
  end

  assign bus.cs_hsync       = r_hsync;
  assign bus.cs_vsync       = r_vsync;
  assign bus.cs_csync       = r_csync;
  assign bus.cs_blank       = r_blank;
  assign bus.cs_cg_enable   = r_cg_enable;
  assign bus.cs_pnsel       = r_pnsel;
  assign bus.cs_hcnt        = r_hcnt;
  assign bus.cs_vcnt        = r_vcnt;
  assign bus.cs_frame_start = r_frame_start;

endmodule

// File: tb/tb_chroma_timing_ctrl.sv
// Directed bench for chroma_timing_ctrl using a shrunken raster (64 ticks x 30/25 lines)
// so whole frames fit in a short run; expected values are hand-derived positions in that raster.
module tb_chroma_timing_ctrl;
  localparam int HT = 64, HS = 5, HAS = 10, HAL = 40;
  localparam int VTP = 30, VTN = 25, VSL = 3, VAS = 6, VAL = 15;
`ifdef CHROMA_SERRATION_EN
  localparam bit SER = 1'b1;
`else
  localparam bit SER = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  chroma_timing_ctrl_if bus();

  chroma_timing_ctrl #(
    .H_TOTAL(HT), .H_SYNC_LEN(HS), .H_ACTIVE_START(HAS), .H_ACTIVE_LEN(HAL),
    .V_TOTAL_PAL(VTP), .V_TOTAL_NTSC(VTN), .V_SYNC_LEN(VSL),
    .V_ACTIVE_START(VAS), .V_ACTIVE_LEN(VAL)
  ) dut (
    .cs_clock  (clk),
    .cs_reset_n(rst_n),
    .bus       (bus)
  );

  // {hsync, vsync, csync, blank, cg_enable, frame_start}
  function automatic logic [5:0] outs();
    return {bus.cs_hsync, bus.cs_vsync, bus.cs_csync, bus.cs_blank,
            bus.cs_cg_enable, bus.cs_frame_start};
  endfunction

  // Advance with tick high until k ticked edges have occurred since reset release.
  task automatic adv_to(input int k);
    while (cyc < k) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.cs_tick       = 1'b0;
    bus.cs_pnsel_req  = 1'b0;
    bus.cs_colour_req = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (outs() !== 6'b111100) begin n_bad++; $display("FAIL reset_outs: got %b want %b", outs(), 6'b111100); end
    n_cmp++; if (bus.cs_hcnt !== 9'd0) begin n_bad++; $display("FAIL reset_hcnt: got %0d want 0", bus.cs_hcnt); end
    n_cmp++; if (bus.cs_vcnt !== 9'd0) begin n_bad++; $display("FAIL reset_vcnt: got %0d want 0", bus.cs_vcnt); end
    n_cmp++; if (bus.cs_pnsel !== 1'b0) begin n_bad++; $display("FAIL reset_pnsel: got %b want 0", bus.cs_pnsel); end
    bus.cs_tick = 1'b1;
    rst_n = 1'b1;
    cyc = 0;
    adv_to(1);
    n_cmp++; if (bus.cs_hcnt !== 9'd1) begin n_bad++; $display("FAIL first_tick_hcnt: got %0d want 1", bus.cs_hcnt); end
    n_cmp++; if (outs() !== {2'b00, (SER ? 1'b0 : 1'b1), 3'b100}) begin n_bad++; $display("FAIL first_tick_outs: got %b want %b", outs(), {2'b00, (SER ? 1'b0 : 1'b1), 3'b100}); end
  endtask

  task automatic test_line_timing();
    adv_to(5);
    n_cmp++; if (outs() !== {2'b00, (SER ? 1'b0 : 1'b1), 3'b100}) begin n_bad++; $display("FAIL h4_outs: got %b want %b", outs(), {2'b00, (SER ? 1'b0 : 1'b1), 3'b100}); end
    adv_to(6);
    n_cmp++; if (outs() !== 6'b100100) begin n_bad++; $display("FAIL h5_outs: got %b want %b", outs(), 6'b100100); end
    adv_to(28);
    n_cmp++; if (outs() !== {2'b10, SER, 3'b100}) begin n_bad++; $display("FAIL h27_csync: got %b want %b", outs(), {2'b10, SER, 3'b100}); end
    adv_to(33);
    n_cmp++; if (outs() !== 6'b100100) begin n_bad++; $display("FAIL h32_csync: got %b want %b", outs(), 6'b100100); end
    adv_to(60);
    n_cmp++; if (outs() !== {2'b10, SER, 3'b100}) begin n_bad++; $display("FAIL h59_csync: got %b want %b", outs(), {2'b10, SER, 3'b100}); end
    adv_to(192);
    n_cmp++; if (outs() !== {2'b10, SER, 3'b100}) begin n_bad++; $display("FAIL last_vsync_tick: got %b want %b", outs(), {2'b10, SER, 3'b100}); end
    n_cmp++; if (bus.cs_vcnt !== 9'd3) begin n_bad++; $display("FAIL line3_vcnt: got %0d want 3", bus.cs_vcnt); end
    adv_to(193);
    n_cmp++; if (outs() !== 6'b010100) begin n_bad++; $display("FAIL vsync_end: got %b want %b", outs(), 6'b010100); end
    adv_to(394);
    n_cmp++; if (outs() !== 6'b111100) begin n_bad++; $display("FAIL pre_active: got %b want %b", outs(), 6'b111100); end
    adv_to(395);
    n_cmp++; if (outs() !== 6'b111000) begin n_bad++; $display("FAIL active_start: got %b want %b", outs(), 6'b111000); end
    adv_to(434);
    n_cmp++; if (outs() !== 6'b111000) begin n_bad++; $display("FAIL active_last: got %b want %b", outs(), 6'b111000); end
    adv_to(435);
    n_cmp++; if (outs() !== 6'b111100) begin n_bad++; $display("FAIL active_end: got %b want %b", outs(), 6'b111100); end
    adv_to(1291);
    n_cmp++; if (outs() !== 6'b111000) begin n_bad++; $display("FAIL last_active_line: got %b want %b", outs(), 6'b111000); end
    adv_to(1355);
    n_cmp++; if (outs() !== 6'b111100) begin n_bad++; $display("FAIL bottom_blank: got %b want %b", outs(), 6'b111100); end
  endtask

  task automatic test_frame_wrap();
    adv_to(1919);
    n_cmp++; if (bus.cs_hcnt !== 9'd63 || bus.cs_vcnt !== 9'd29) begin n_bad++; $display("FAIL pal_last_pos: got %0d/%0d want 63/29", bus.cs_hcnt, bus.cs_vcnt); end
    adv_to(1920);
    n_cmp++; if (bus.cs_vcnt !== 9'd0 || bus.cs_hcnt !== 9'd0) begin n_bad++; $display("FAIL pal_wrap_pos: got %0d/%0d want 0/0", bus.cs_hcnt, bus.cs_vcnt); end
    n_cmp++; if (outs() !== 6'b111100) begin n_bad++; $display("FAIL pal_wrap_outs: got %b want %b", outs(), 6'b111100); end
    adv_to(1921);
    n_cmp++; if (outs() !== {2'b00, (SER ? 1'b0 : 1'b1), 3'b101}) begin n_bad++; $display("FAIL frame_start_pulse: got %b want %b", outs(), {2'b00, (SER ? 1'b0 : 1'b1), 3'b101}); end
    adv_to(1922);
    n_cmp++; if (outs() !== {2'b00, (SER ? 1'b0 : 1'b1), 3'b100}) begin n_bad++; $display("FAIL frame_start_end: got %b want %b", outs(), {2'b00, (SER ? 1'b0 : 1'b1), 3'b100}); end
    adv_to(2314);
    n_cmp++; if (outs() !== 6'b111100) begin n_bad++; $display("FAIL colour_pre_active: got %b want %b", outs(), 6'b111100); end
    adv_to(2315);
    n_cmp++; if (outs() !== 6'b111010) begin n_bad++; $display("FAIL colour_active: got %b want %b", outs(), 6'b111010); end
    adv_to(2355);
    n_cmp++; if (outs() !== 6'b111100) begin n_bad++; $display("FAIL colour_hblank: got %b want %b", outs(), 6'b111100); end
  endtask

  task automatic test_mode_switch();
    adv_to(2560);
    bus.cs_pnsel_req = 1'b1;
    adv_to(2561);
    n_cmp++; if (bus.cs_pnsel !== 1'b0) begin n_bad++; $display("FAIL pnsel_midframe: got %b want 0", bus.cs_pnsel); end
    adv_to(3839);
    n_cmp++; if (bus.cs_pnsel !== 1'b0 || bus.cs_vcnt !== 9'd29) begin n_bad++; $display("FAIL old_frame_len: got pnsel %b vcnt %0d want 0/29", bus.cs_pnsel, bus.cs_vcnt); end
    adv_to(3840);
    n_cmp++; if (bus.cs_pnsel !== 1'b1 || bus.cs_vcnt !== 9'd0) begin n_bad++; $display("FAIL pnsel_applied: got pnsel %b vcnt %0d want 1/0", bus.cs_pnsel, bus.cs_vcnt); end
    adv_to(3841);
    n_cmp++; if (bus.cs_frame_start !== 1'b1) begin n_bad++; $display("FAIL fs_pal_end: got %b want 1", bus.cs_frame_start); end
    adv_to(5439);
    n_cmp++; if (bus.cs_vcnt !== 9'd24 || bus.cs_hcnt !== 9'd63 || bus.cs_frame_start !== 1'b0) begin n_bad++; $display("FAIL ntsc_last_pos: got %0d/%0d fs %b want 63/24 fs 0", bus.cs_hcnt, bus.cs_vcnt, bus.cs_frame_start); end
    adv_to(5440);
    n_cmp++; if (bus.cs_vcnt !== 9'd0 || bus.cs_hcnt !== 9'd0) begin n_bad++; $display("FAIL ntsc_wrap: got %0d/%0d want 0/0", bus.cs_hcnt, bus.cs_vcnt); end
    adv_to(5441);
    n_cmp++; if (bus.cs_frame_start !== 1'b1) begin n_bad++; $display("FAIL fs_ntsc_end: got %b want 1", bus.cs_frame_start); end
  endtask

  task automatic test_reset_midline();
    adv_to(6750);
    n_cmp++; if (bus.cs_hcnt !== 9'd30 || bus.cs_vcnt !== 9'd20) begin n_bad++; $display("FAIL pre_reset_pos: got %0d/%0d want 30/20", bus.cs_hcnt, bus.cs_vcnt); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (outs() !== 6'b111100) begin n_bad++; $display("FAIL async_reset_outs: got %b want %b", outs(), 6'b111100); end
    n_cmp++; if (bus.cs_hcnt !== 9'd0 || bus.cs_vcnt !== 9'd0 || bus.cs_pnsel !== 1'b0) begin n_bad++; $display("FAIL async_reset_state: got %0d/%0d pnsel %b want 0/0/0", bus.cs_hcnt, bus.cs_vcnt, bus.cs_pnsel); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.cs_hcnt !== 9'd0) begin n_bad++; $display("FAIL reset_hold_hcnt: got %0d want 0", bus.cs_hcnt); end
    rst_n = 1'b1;
    cyc = 0;
    adv_to(1);
    n_cmp++; if (bus.cs_hcnt !== 9'd1 || bus.cs_pnsel !== 1'b0) begin n_bad++; $display("FAIL restart_pos: got hcnt %0d pnsel %b want 1/0", bus.cs_hcnt, bus.cs_pnsel); end
    n_cmp++; if (outs() !== {2'b00, (SER ? 1'b0 : 1'b1), 3'b100}) begin n_bad++; $display("FAIL restart_outs: got %b want %b", outs(), {2'b00, (SER ? 1'b0 : 1'b1), 3'b100}); end
  endtask

  task automatic test_tick_gating();
    for (int i = 0; i < 6; i++) begin
      bus.cs_tick = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.cs_hcnt !== 9'(2 + i)) begin n_bad++; $display("FAIL gate_tick_hcnt%0d: got %0d want %0d", i, bus.cs_hcnt, 2 + i); end
      n_cmp++; if (bus.cs_hsync !== ((1 + i) >= HS)) begin n_bad++; $display("FAIL gate_tick_hsync%0d: got %b want %b", i, bus.cs_hsync, ((1 + i) >= HS)); end
      bus.cs_tick = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.cs_hcnt !== 9'(2 + i)) begin n_bad++; $display("FAIL gate_hold_hcnt%0d: got %0d want %0d", i, bus.cs_hcnt, 2 + i); end
      n_cmp++; if (bus.cs_hsync !== ((2 + i) >= HS)) begin n_bad++; $display("FAIL gate_hold_hsync%0d: got %b want %b", i, bus.cs_hsync, ((2 + i) >= HS)); end
    end
    n_cmp++; if (bus.cs_vcnt !== 9'd0) begin n_bad++; $display("FAIL gate_vcnt: got %0d want 0", bus.cs_vcnt); end
    bus.cs_tick = 1'b1;
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_wrap();
    test_mode_switch();
    test_reset_midline();
    test_tick_gating();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/chroma_timing_ctrl.md
Name: chroma_timing_ctrl

Overview:
- Line/frame sequencer for the composite chroma path. It drives the chroma generator's hsync, colour-enable and PAL/NTSC select inputs, and the matching csync/blank to the video DAC.
- Counts pixel ticks into lines and frames and walks a vertical-region FSM.
- Applies PAL/NTSC and colour on/off requests only at safe boundaries, so carrier phase and burst never glitch mid-frame.

Parameters:
- H_TOTAL, 448, ticks per line (64 us at 7 MHz).
- H_SYNC_LEN, 33, hsync low width in ticks.
- H_ACTIVE_START, 80, first active tick of a line.
- H_ACTIVE_LEN, 352, active ticks per line.
- V_TOTAL_PAL, 312, lines per frame in PAL.
- V_TOTAL_NTSC, 262, lines per frame in NTSC.
- V_SYNC_LEN, 4, vsync lines starting at line 0.
- V_ACTIVE_START, 16, first active line.
- V_ACTIVE_LEN, 240, active lines per frame.

Ports:
- cs_clock  in  1  system clock
- cs_reset_n  in  1  asynchronous active-low reset
- cs_tick  in  1  pixel clock-enable; counters advance only when high
- cs_pnsel_req  in  1  requested system: 0 = PAL, 1 = NTSC
- cs_colour_req  in  1  requested colour enable
- cs_hsync  out  1  line sync, active low, to chroma generator
- cs_vsync  out  1  frame sync, active low
- cs_csync  out  1  composite sync, active low
- cs_blank  out  1  high outside the active window
- cs_cg_enable  out  1  colour enable to chroma generator
- cs_pnsel  out  1  applied system select
- cs_hcnt  out  9  horizontal tick counter
- cs_vcnt  out  9  line counter
- cs_frame_start  out  1  one-clock pulse at frame wrap

Behaviour:
- Reset values (async, immediate): hcnt=0, vcnt=0, state=VSYNC, pnsel=0, colour latch=0. Outputs: hsync=1, vsync=1, csync=1, blank=1, cg_enable=0, frame_start=0.
- Counters advance on a cs_clock edge with cs_tick=1 and hold otherwise:
  - hcnt: 0..H_TOTAL-1, then wraps to 0.
  - On hcnt wrap, vcnt increments; vcnt wraps at vtot-1, where vtot = V_TOTAL_NTSC if cs_pnsel else V_TOTAL_PAL.
- Frame wrap = tick with hcnt=H_TOTAL-1 and vcnt=vtot-1. On that edge:
  - cs_pnsel <= cs_pnsel_req; colour latch <= cs_colour_req.
  - cs_frame_start pulses for exactly one cs_clock on the following edge.
  - Request changes at any other time are ignored until the next frame wrap.
- Mode change takes effect from the next frame: the new vtot applies to the next frame's wrap. A frame already in progress finishes with its old length.
- Vertical FSM, updated on line wrap and decoded from the next vcnt:
  - VSYNC: lines [0, V_SYNC_LEN)
  - TOP_BLANK: lines [V_SYNC_LEN, V_ACTIVE_START)
  - ACTIVE: lines [V_ACTIVE_START, V_ACTIVE_START+V_ACTIVE_LEN)
  - BOTTOM_BLANK: remaining lines up to vtot-1
  - Transitions run VSYNC -> TOP_BLANK -> ACTIVE -> BOTTOM_BLANK -> VSYNC (at frame wrap) only. There are no skips.
- Outputs are registered decodes of the current counters/state, so latency is 1 cs_clock after a counter update:
  - hsync = 0 iff hcnt < H_SYNC_LEN, on every line including vsync lines, so PAL line alternation stays continuous.
  - vsync = 0 iff state = VSYNC.
  - blank = 0 iff state = ACTIVE and hcnt is in [H_ACTIVE_START, H_ACTIVE_START+H_ACTIVE_LEN).
  - cg_enable = colour latch AND NOT blank.
- Parameter rules:
  - Widths are fixed at 9 bits; any parameter >= 512 is illegal.
  - V_ACTIVE_START+V_ACTIVE_LEN must be <= V_TOTAL_NTSC.
- Reset asserted mid-line: all state is cleared asynchronously. The first tick after release counts hcnt 0 -> 1. hsync goes low one clock after release, since hcnt=0 decodes as sync.

Optional Feature:
- Macro: CHROMA_SERRATION_EN.
- Defined: during VSYNC lines, csync is low except during serration gaps of H_SYNC_LEN ticks ending at each half-line. The gaps are hcnt in [H_TOTAL/2-H_SYNC_LEN, H_TOTAL/2) and [H_TOTAL-H_SYNC_LEN, H_TOTAL). Outside VSYNC, csync = hsync.
- Undefined: csync = NOT(hsync_active XOR vsync_active), i.e. line sync inverted during vsync lines.

Test Plan:
- Reset release, cs_tick tied high, PAL → hsync low for hcnt 0..32 and high at 33. cs_frame_start pulses every 448*312 = 139776 clocks. vsync is low for 4*448 = 1792 ticks.
- Toggle cs_pnsel_req to 1 mid-frame at line 100 → cs_pnsel stays 0 until the current 312-line frame wraps, then reads 1. The next frame is 262 lines (117376 ticks).
- cs_colour_req=1 from frame start → cg_enable high only on lines 16..255 at hcnt 80..431 (1-clock latency). It is 0 during blank and in the first frame before the latch takes the request.
- cs_tick toggling 1/0 every clock → counters advance every second clock, and outputs are unchanged between ticks.
- Assert cs_reset_n at line 200, hcnt 300 → immediately hcnt=vcnt=0, outputs at reset values, cs_pnsel=0. After release, the sequence restarts from VSYNC.
- With CHROMA_SERRATION_EN on a vsync line → csync high at hcnt 191..223 and 415..447, low elsewhere. Without the macro → csync high at hcnt 0..32, low at 33..447.
